// File: rtl/logic_unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter_pkg
// Purpose  : Shared opcode, requester-ID and output-stage state definitions
//            for the two-requester shared 16-bit logic unit.
// Contents : logic_op_t   - 2-bit opcode type
//            LOGIC_OR / LOGIC_AND / LOGIC_XOR / LOGIC_ANDN opcode constants
//            REQ0 / REQ1  - requester ID constants
//            out_state_e  - output register state (EMPTY / FULL)
// Revision : 1.0 - initial release
// ============================================================================
package logic_unit_arbiter_pkg;

  typedef logic [1:0] logic_op_t;

  localparam logic_op_t LOGIC_OR   = 2'b00;
  localparam logic_op_t LOGIC_AND  = 2'b01;
  localparam logic_op_t LOGIC_XOR  = 2'b10;
  localparam logic_op_t LOGIC_ANDN = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage : logic_unit_arbiter_pkg
`default_nettype wire

// File: rtl/logic_unit_arbiter_logic16_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic16_unit
// Purpose  : Purely combinational bitwise logic unit (OR / AND / XOR / ANDN).
//            No carry and no flags; every result bit depends only on the
//            matching operand bits.
// Ports    : op     in  2      opcode (logic_op_t)
//            a      in  WIDTH  operand A
//            b      in  WIDTH  operand B
//            result out WIDTH  op(a, b)
// Revision : 1.0 - initial release
// ============================================================================
module logic16_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic_op_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      LOGIC_OR:   result = a | b;
      LOGIC_AND:  result = a & b;
      LOGIC_XOR:  result = a ^ b;
      LOGIC_ANDN: result = a & ~b;
      default:    result = '0;
    endcase
  end

endmodule : logic16_unit
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : Shares one bitwise logic unit between two valid/ready
//            requesters. A round-robin arbiter selects one request per cycle;
//            the result is captured in a single output register tagged with
//            the owning requester ID and honours consumer back-pressure.
//            Capture and drain may coincide, sustaining 1 op/cycle.
// Ports    : clk, rst_n (async, active low)
//            req0_valid/ready/op/a/b - requester 0
//            req1_valid/ready/op/a/b - requester 1
//            rsp_valid/ready/id/data - response
//            rsp_zero                - result-is-zero flag (optional)
// Options  : LOGIC_UNIT_ARBITER_ZERO_FLAG_EN - when defined, adds the
//            registered rsp_zero output.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
  ,
  output logic             rsp_zero
`endif
);

  out_state_e       state;
  logic             last_grant;
  logic             can_accept;
  logic             grant;
  logic             handshake;
  logic_op_t        sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  // A result can be captured when the register is empty or is being drained
  // in this very cycle.
  assign can_accept = (state == OUT_EMPTY) || rsp_ready;

  // Round-robin: on contention the requester that did not win last goes.
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = REQ1;
    else                          grant = REQ0;
  end

  assign req0_ready = can_accept && (grant == REQ0) && req0_valid;
  assign req1_ready = can_accept && (grant == REQ1) && req1_valid;
  assign handshake  = req0_ready || req1_ready;

  // Operand steering follows the grant so the single unit serves the winner.
  assign sel_op = (grant == REQ1) ? req1_op : req0_op;
  assign sel_a  = (grant == REQ1) ? req1_a  : req0_a;
  assign sel_b  = (grant == REQ1) ? req1_b  : req0_b;

  logic16_unit #(
    .WIDTH (WIDTH)
  ) u_logic16_unit (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (result)
  );

  // Output-stage FSM with registered outputs. rsp_data/rsp_id keep their
  // last values after a drain; only rsp_valid falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OUT_EMPTY;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= REQ0;
      last_grant <= REQ1;
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
      rsp_zero   <= 1'b1;
`endif
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (handshake) begin
            state      <= OUT_FULL;
            rsp_valid  <= 1'b1;
            rsp_data   <= result;
            rsp_id     <= grant;
            last_grant <= grant;
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
            rsp_zero   <= ~|result;
`endif
          end
        end
        OUT_FULL: begin
          if (handshake) begin
            // Drain and refill in the same edge.
            state      <= OUT_FULL;
            rsp_valid  <= 1'b1;
            rsp_data   <= result;
            rsp_id     <= grant;
            last_grant <= grant;
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
            rsp_zero   <= ~|result;
`endif
          end else if (rsp_ready) begin
            state     <= OUT_EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= OUT_EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : logic_unit_arbiter
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Purpose  : Directed self-checking bench for logic_unit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
  logic             rsp_zero;
`endif

  int errors = 0;
  int checks = 0;

  logic_unit_arbiter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
    ,
    .rsp_zero   (rsp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; readys are sampled on the
  // falling edge, registered outputs #1 after the next rising edge.
  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic to_post_edge();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]       op_tab  [4];
  logic [WIDTH-1:0] exp_tab [4];

  initial begin
    op_tab[0] = 2'b01; exp_tab[0] = 16'h0F00;  // AND
    op_tab[1] = 2'b10; exp_tab[1] = 16'hF0F0;  // XOR
    op_tab[2] = 2'b11; exp_tab[2] = 16'hF000;  // ANDN
    op_tab[3] = 2'b00; exp_tab[3] = 16'hFFF0;  // OR

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;

    // Reset state
    #1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
    check("reset_rsp_zero", {31'd0, rsp_zero}, 32'd1);
`endif
    to_post_edge();
    to_post_edge();
    rst_n = 1'b1;

    // Single request on req0: OR 00F0 | 0F00
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h00F0; req0_b = 16'h0F00;
    to_negedge();
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    to_post_edge();
    req0_valid = 1'b0;
    check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("single_rsp_data", {16'd0, rsp_data}, 32'h0FF0);

    // All opcodes back-to-back on req1
    req1_valid = 1'b1; req1_a = 16'hFF00; req1_b = 16'h0FF0;
    for (int i = 0; i < 4; i++) begin
      req1_op = op_tab[i];
      to_negedge();
      check($sformatf("op%0d_req1_ready", i), {31'd0, req1_ready}, 32'd1);
      to_post_edge();
      check($sformatf("op%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("op%0d_rsp_id", i), {31'd0, rsp_id}, 32'd1);
      check($sformatf("op%0d_rsp_data", i), {16'd0, rsp_data}, {16'd0, exp_tab[i]});
    end
    req1_valid = 1'b0;
    to_post_edge();
    check("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("drain_rsp_data_held", {16'd0, rsp_data}, 32'hFFF0);
    check("drain_rsp_id_held", {31'd0, rsp_id}, 32'd1);

    // Contention: last winner was req1, so req0 goes first
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0011; req0_b = 16'h0100;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'hFFFF; req1_b = 16'h00AA;
    for (int i = 0; i < 4; i++) begin
      to_negedge();
      check($sformatf("cont%0d_req0_ready", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont%0d_req1_ready", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      to_post_edge();
      check($sformatf("cont%0d_rsp_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d_rsp_data", i), {16'd0, rsp_data}, (i % 2 == 0) ? 32'h0111 : 32'h00AA);
      check($sformatf("cont%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    to_post_edge();

    // Back-pressure: hold 1234 while req0 waits with XOR FFFF^0001
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h1234; req0_b = 16'h0000;
    to_post_edge();
    check("bp_first_rsp_data", {16'd0, rsp_data}, 32'h1234);
    rsp_ready = 1'b0;
    req0_op = 2'b10; req0_a = 16'hFFFF; req0_b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      to_negedge();
      check($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
      to_post_edge();
      check($sformatf("bp%0d_rsp_data", i), {16'd0, rsp_data}, 32'h1234);
      check($sformatf("bp%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    to_negedge();
    check("bp_release_req0_ready", {31'd0, req0_ready}, 32'd1);
    to_post_edge();
    req0_valid = 1'b0;
    check("bp_release_rsp_data", {16'd0, rsp_data}, 32'hFFFE);
    check("bp_release_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // Async reset while FULL (last winner req0 before reset)
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hF0F0; req0_b = 16'hFF00;
    to_post_edge();
    req0_valid = 1'b0;
    check("prerst_rsp_data", {16'd0, rsp_data}, 32'hF000);
    check("prerst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0004; req1_b = 16'h0008;
    to_negedge();
    check("postrst_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("postrst_req1_ready", {31'd0, req1_ready}, 32'd0);
    to_post_edge();
    check("postrst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("postrst_rsp_data", {16'd0, rsp_data}, 32'h0003);
    req0_valid = 1'b0;
    to_post_edge();
    req1_valid = 1'b0;
    check("postrst_second_rsp_id", {31'd0, rsp_id}, 32'd1);
    check("postrst_second_rsp_data", {16'd0, rsp_data}, 32'h000C);

    // Zero result then non-zero result
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hAAAA; req0_b = 16'h5555;
    to_post_edge();
    check("zero_and_rsp_data", {16'd0, rsp_data}, 32'h0000);
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
    check("zero_and_rsp_zero", {31'd0, rsp_zero}, 32'd1);
`endif
    req0_op = 2'b00;
    to_post_edge();
    req0_valid = 1'b0;
    check("zero_or_rsp_data", {16'd0, rsp_data}, 32'hFFFF);
`ifdef LOGIC_UNIT_ARBITER_ZERO_FLAG_EN
    check("zero_or_rsp_zero", {31'd0, rsp_zero}, 32'd0);
`endif
    to_post_edge();
    check("final_drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("final_drain_rsp_data", {16'd0, rsp_data}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_logic_unit_arbiter
`default_nettype wire
